// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, stall/flush,
// mult/div occupancy tracking and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        branchD,
  input  logic        pcsrcD,
  input  logic        mdStartD,
  input  logic        mdUseD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        mdStartE,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteW,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        mdBusy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [3:0] MD_RELOAD = 4'(MD_LATENCY - 1);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic lwstall, brstall, mdstall, stall;
  logic busy;

  // Register 0 is hard-wired, so it never creates a dependence.
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (RegWriteM && hit(WriteRegM, src))      return 2'b10;
    else if (RegWriteW && hit(WriteRegW, src)) return 2'b01;
    else                                       return 2'b00;
  endfunction

  always_comb begin
    busy    = (state_q == BUSY);
    lwstall = MemtoRegE && (hit(WriteRegE, rsD) || hit(WriteRegE, rtD));
    brstall = branchD &&
              ((RegWriteE && (hit(WriteRegE, rsD) || hit(WriteRegE, rtD))) ||
               (MemtoRegM && (hit(WriteRegM, rsD) || hit(WriteRegM, rtD))));
    mdstall = busy && (mdUseD || mdStartD);
    stall   = !rst && (lwstall || brstall || mdstall);
  end

  always_comb begin
    StallF       = stall;
    StallD       = stall;
    FlushE       = stall;
    FlushD       = !rst && pcsrcD && !stall;
    ForwardAE    = rst ? 2'b00 : fwd_sel(rsE);
    ForwardBE    = rst ? 2'b00 : fwd_sel(rtE);
    ForwardAD    = !rst && RegWriteM && hit(WriteRegM, rsD);
    ForwardBD    = !rst && RegWriteM && hit(WriteRegM, rtD);
    mdBusy       = !rst && busy;
    stall_cycles = rst ? '0 : stall_cycles_q;
  end

  // A new mult/div reloads the count even when busy, taking priority over the exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mdStartE) begin
      state_d = BUSY;
      cnt_d   = MD_RELOAD;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = IDLE;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: cycle-level reference model plus directed
// literal checks and randomized traffic.
module tb_hazard_ctrl;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic        branchD, pcsrcD, mdStartD, mdUseD;
  logic        RegWriteE, MemtoRegE, mdStartE, RegWriteM, MemtoRegM, RegWriteW;
  logic        StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, mdBusy;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // Model state: cycle index, first cycle the mult/div unit is free again, counter.
  int      cyc = 0;
  int      busy_end = 0;
  longint  exp_cnt = 0;

  hazard_ctrl #(.MD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .pcsrcD(pcsrcD),
    .mdStartD(mdStartD), .mdUseD(mdUseD), .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .mdStartE(mdStartE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .mdBusy(mdBusy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic bit m_busy();
    return cyc < busy_end;
  endfunction

  function automatic bit m_stall();
    bit lw, br, md;
    lw = MemtoRegE && (dep(WriteRegE, rsD) || dep(WriteRegE, rtD));
    br = branchD && ((RegWriteE && (dep(WriteRegE, rsD) || dep(WriteRegE, rtD))) ||
                     (MemtoRegM && (dep(WriteRegM, rsD) || dep(WriteRegM, rtD))));
    md = m_busy() && (mdUseD || mdStartD);
    return !rst && (lw || br || md);
  endfunction

  function automatic int m_fwd(input logic [4:0] src);
    if (RegWriteM && dep(WriteRegM, src)) return 2;
    if (RegWriteW && dep(WriteRegW, src)) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_cnt  = 0;
      busy_end = 0;
    end else begin
      if (m_stall() && exp_cnt < 64'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
      if (mdStartE) busy_end = cyc + L;
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    bit s;
    s = m_stall();
    chk("StallF", StallF, s);
    chk("StallD", StallD, s);
    chk("FlushE", FlushE, s);
    chk("FlushD", FlushD, !rst && pcsrcD && !s);
    chk("ForwardAE", ForwardAE, rst ? 0 : m_fwd(rsE));
    chk("ForwardBE", ForwardBE, rst ? 0 : m_fwd(rtE));
    chk("ForwardAD", ForwardAD, !rst && RegWriteM && dep(WriteRegM, rsD));
    chk("ForwardBD", ForwardBD, !rst && RegWriteM && dep(WriteRegM, rtD));
    chk("mdBusy", mdBusy, !rst && m_busy());
    chk("stall_cycles", stall_cycles, rst ? 0 : exp_cnt);
  endtask

  task automatic clear_inputs();
    rst = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    branchD = 0; pcsrcD = 0; mdStartD = 0; mdUseD = 0;
    RegWriteE = 0; MemtoRegE = 0; mdStartE = 0;
    RegWriteM = 0; MemtoRegM = 0; RegWriteW = 0;
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 2ns later.
  task automatic next_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic settle();
    #2;
    check_model();
  endtask

  task automatic do_reset();
    next_cycle(); rst = 1; settle();
    chk("rst_stall", StallD, 0);
    chk("rst_cnt", stall_cycles, 0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    do_reset();

    // Forwarding priority
    next_cycle(); RegWriteM = 1; RegWriteW = 1; WriteRegM = 5; WriteRegW = 5; rsE = 5;
    settle(); chk("fwd_mem", ForwardAE, 2);
    next_cycle(); RegWriteW = 1; WriteRegM = 5; WriteRegW = 5; rsE = 5;
    settle(); chk("fwd_wb", ForwardAE, 1);
    next_cycle(); RegWriteM = 1; RegWriteW = 1; rtE = 0;
    settle(); chk("fwd_r0", ForwardBE, 0);

    // Load-use: one stall cycle, then the load sits in MEM
    next_cycle(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; rtD = 8;
    settle(); chk("lu_stall", StallD, 1); chk("lu_flushE", FlushE, 1); chk("lu_cnt0", stall_cycles, 0);
    next_cycle(); MemtoRegM = 1; RegWriteM = 1; WriteRegM = 8; rtD = 8;
    settle(); chk("lu_release", StallD, 0); chk("lu_cnt1", stall_cycles, 1);
    next_cycle(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 0; rtD = 0;
    settle(); chk("lu_r0", StallD, 0);

    // Branch behind a load: two stall cycles, redirect only once released
    next_cycle(); branchD = 1; pcsrcD = 1; rsD = 9; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 9;
    settle(); chk("br_stall1", StallD, 1); chk("br_flushD1", FlushD, 0);
    next_cycle(); branchD = 1; pcsrcD = 1; rsD = 9; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 9;
    settle(); chk("br_stall2", StallD, 1); chk("br_flushD2", FlushD, 0);
    next_cycle(); branchD = 1; pcsrcD = 1; rsD = 9; RegWriteW = 1; WriteRegW = 9;
    settle(); chk("br_release", StallD, 0); chk("br_flushD3", FlushD, 1); chk("br_cnt", stall_cycles, 3);

    // Mult/div with mfhi held in ID
    next_cycle(); mdStartE = 1; mdUseD = 1;
    settle(); chk("md_t0", mdBusy, 0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle(); mdUseD = 1;
      settle(); chk("md_busy", mdBusy, 1); chk("md_stall", StallD, 1);
    end
    next_cycle(); mdUseD = 1;
    settle(); chk("md_done", mdBusy, 0); chk("md_release", StallD, 0); chk("md_cnt", stall_cycles, 6);

    // Reset in the middle of BUSY
    next_cycle(); mdStartE = 1;
    settle();
    next_cycle(); mdUseD = 1;
    settle(); chk("mr_busy", mdBusy, 1);
    next_cycle(); rst = 1; mdUseD = 1; pcsrcD = 1; RegWriteM = 1; WriteRegM = 3; rsE = 3; rsD = 3;
    settle();
    chk("mr_busy_rst", mdBusy, 0); chk("mr_stall_rst", StallD, 0); chk("mr_flushD_rst", FlushD, 0);
    chk("mr_fwdE_rst", ForwardAE, 0); chk("mr_fwdD_rst", ForwardAD, 0);
    next_cycle(); mdUseD = 1;
    settle(); chk("mr_after", mdBusy, 0); chk("mr_nostall", StallD, 0); chk("mr_cnt", stall_cycles, 0);

    // Saturation: preload the counter just below the ceiling
    next_cycle(); mdStartD = 0; MemtoRegE = 1; WriteRegE = 4; rsD = 4;
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    exp_cnt = 64'hFFFF_FFFD;
    #1;
    release dut.stall_cycles_q;
    #1; check_model(); chk("sat_pre", stall_cycles, 64'hFFFF_FFFD);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); MemtoRegE = 1; WriteRegE = 4; rsD = 4;
      settle();
      chk("sat_val", stall_cycles, (k == 0) ? 64'hFFFF_FFFE : 64'hFFFF_FFFF);
    end

    do_reset();

    // Randomized traffic on a small register set so dependences are frequent
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst       = ($urandom_range(0, 49) == 0);
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      rsE       = 5'($urandom_range(0, 3));
      rtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      branchD   = ($urandom_range(0, 2) == 0);
      pcsrcD    = ($urandom_range(0, 2) == 0);
      mdStartD  = ($urandom_range(0, 7) == 0);
      mdUseD    = ($urandom_range(0, 3) == 0);
      RegWriteE = 1'($urandom);
      MemtoRegE = ($urandom_range(0, 3) == 0);
      mdStartE  = ($urandom_range(0, 9) == 0);
      RegWriteM = 1'($urandom);
      MemtoRegM = ($urandom_range(0, 3) == 0);
      RegWriteW = 1'($urandom);
      settle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
